cpu_bus_bridge: RTL

//  Parametrised successor to the top-level CPU strobe latch: turns asynchronous csr_n/csw_n/mode

---
 rtl/cpu_bus_bridge_if.sv | 22 ++
 rtl/cpu_bus_bridge.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_bridge_if.sv
// rtl/cpu_bus_bridge_if.sv - downstream VDP req/ack transaction bus between bridge (master) and core (slave)
interface cpu_bus_bridge_if #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 8
);
  logic              req;
  logic              wrt;
  logic [ADDR_W-1:0] adr;
  logic [DATA_W-1:0] dbo;
  logic              ack;
  logic [DATA_W-1:0] dbi;

  modport master (
    output req, wrt, adr, dbo,
    input  ack, dbi
  );

  modport slave (
    input  req, wrt, adr, dbo,
    output ack, dbi
  );
endinterface

// File: rtl/cpu_bus_bridge.sv
// rtl/cpu_bus_bridge.sv - host csr_n/csw_n strobes to VDP req/ack bridge with posted-write FIFO
// Optional macro CPU_BUS_WAIT_EN adds wait_n and stalls (instead of dropping) full-FIFO writes.
module cpu_bus_bridge #(
  parameter int ADDR_W     = 2,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int FILTER_LEN = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              csr_n,
  input  logic              csw_n,
  input  logic [ADDR_W-1:0] mode,
  input  logic [DATA_W-1:0] cd_in,
  output logic [DATA_W-1:0] cd_out,
  output logic              cd_oe,
  output logic              overflow,
`ifdef CPU_BUS_WAIT_EN
  output logic              wait_n,
`endif
  cpu_bus_bridge_if.master  vdp
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int FCNT_W = $clog2(FILTER_LEN + 1);
  localparam int ENT_W  = ADDR_W + DATA_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_REQ  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t state;

  // Index 0 = csr, index 1 = csw.
  logic [1:0]        sync1;
  logic [1:0]        sync2;
  logic [1:0]        strb_f;
  logic [FCNT_W-1:0] fcnt [2];

  logic [ADDR_W-1:0] cap_mode;
  logic [DATA_W-1:0] cap_data;

  logic [ENT_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic              req_q;
  logic              wrt_q;
  logic [ADDR_W-1:0] adr_q;
  logic [DATA_W-1:0] dbo_q;

  logic              csr_f;
  logic              csw_f;
  logic              full;
  logic              empty;
  logic              wr_request;
  logic              push;
  logic              pop;
  logic              issue_wr;
  logic              issue_rd;
  logic [ENT_W-1:0]  head;

  assign csr_f = strb_f[0];
  assign csw_f = strb_f[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= 2'b11;
      sync2   <= 2'b11;
      strb_f  <= 2'b11;
      fcnt[0] <= '0;
      fcnt[1] <= '0;
    end else begin
      sync1 <= {csw_n, csr_n};
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == strb_f[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FCNT_W'(FILTER_LEN - 1)) begin
          strb_f[i] <= sync2[i];
          fcnt[i]   <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + FCNT_W'(1);
        end
      end
    end
  end

  // While both filtered strobes are released the capture tracks the pins, so it
  // freezes on exactly the cycle either filtered strobe falls.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_mode <= '0;
      cap_data <= '0;
    end else if (&strb_f) begin
      cap_mode <= mode;
      cap_data <= cd_in;
    end
  end

  always_comb begin
    full       = (count == CNT_W'(FIFO_DEPTH));
    empty      = (count == '0);
    pop        = req_q & wrt_q & vdp.ack;
    wr_request = (state == IDLE) & ~csw_f & csr_f;
    push       = wr_request & (~full | pop);
    // An empty FIFO bypasses straight to the bus so req follows the push by one cycle.
    head       = empty ? {cap_mode, cap_data} : mem[rd_ptr];
    issue_wr   = ~req_q & (state != RD_REQ) & (~empty | push);
    issue_rd   = ~req_q & (state == RD_WAIT) & empty;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cap_mode, cap_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      req_q    <= 1'b0;
      wrt_q    <= 1'b0;
      adr_q    <= '0;
      dbo_q    <= '0;
      cd_out   <= '0;
      overflow <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end

      if (req_q) begin
        if (vdp.ack) req_q <= 1'b0;
      end else if (issue_wr) begin
        req_q          <= 1'b1;
        wrt_q          <= 1'b1;
        {adr_q, dbo_q} <= head;
      end else if (issue_rd) begin
        req_q <= 1'b1;
        wrt_q <= 1'b0;
        adr_q <= cap_mode;
        dbo_q <= '0;
      end

      case (state)
        IDLE: begin
          if (!csw_f && !csr_f) begin
            state <= RELEASE;
          end else if (!csw_f) begin
            if (push) begin
              state <= RELEASE;
            end else begin
`ifdef CPU_BUS_WAIT_EN
              state <= IDLE;
`else
              overflow <= 1'b1;
              state    <= RELEASE;
`endif
            end
          end else if (!csr_f) begin
            state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (issue_rd) state <= RD_REQ;
        end
        RD_REQ: begin
          if (req_q && !wrt_q && vdp.ack) begin
            cd_out <= vdp.dbi;
            state  <= RELEASE;
          end
        end
        RELEASE: begin
          if (csr_f && csw_f) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign vdp.req = req_q;
  assign vdp.wrt = wrt_q;
  assign vdp.adr = adr_q;
  assign vdp.dbo = dbo_q;
  assign cd_oe   = ~csr_f;

`ifdef CPU_BUS_WAIT_EN
  assign wait_n = ~((state == RD_WAIT) | (state == RD_REQ) |
                    ((state == IDLE) & full & ~csw_f));
`endif

endmodule
